// File: rtl/decode_opc_queue.sv
// decode_opc_queue: opcode-map decode feeding a DEPTH-entry valid/ready record FIFO
module decode_opc_queue #(
    parameter int INSTR_W = 72,
    parameter int DEPTH   = 4,
    parameter int OPC_W   = 6,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic                   in_is_2byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPC_W-1:0]       out_opc,
    output logic [3:0]             out_opnd_form,
    output logic [1:0]             out_opnd_count,
    output logic                   out_imm_1byte,
    output logic                   out_reg_1byte,
    output logic [5:0]             out_opnd_rw,
    output logic                   out_illegal,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [3:0] F_NONE = 4'd0, F_RM_REG = 4'd1, F_REG_RM = 4'd2, F_ACC_IMM = 4'd3,
                           F_REG_OP = 4'd4, F_REL = 4'd5, F_REG_RM_IMM = 4'd6;
    localparam logic [OPC_W-1:0] C_INC = 9, C_DEC = 10, C_PUSH = 11, C_POP = 12, C_JCC8 = 13,
                                 C_MOV = 14, C_NOP = 15, C_RET = 16, C_CALL = 17, C_JMP = 18,
                                 C_JCC32 = 19, C_IMUL2 = 20, C_MOVZX = 21, C_CPUID = 22, C_IMUL3 = 23;
    typedef struct packed {
        logic [OPC_W-1:0]   opc;
        logic [3:0]         form;
        logic [1:0]         cnt;
        logic               imm1;
        logic               reg1;
        logic [5:0]         rw;
        logic               ill;
        logic [INSTR_W-1:0] instr;
    } rec_t;
    rec_t       dec, head;
    rec_t       mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [7:0] op;
    logic       push, pop;
    assign op        = in_instr[7:0];
    assign in_ready  = count < FULL;
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    // opcode map: one-byte and 0x0F-escaped tables; anything unmatched stays all-zero and is illegal
    always_comb begin
        dec = '0;
        dec.instr = in_instr;
        if (!in_is_2byte) begin
            if (op[7:6] == 2'b00 && op[2:0] < 3'd6) begin
                dec.opc  = OPC_W'(op[5:3]) + OPC_W'(1);
                dec.form = op[2] ? F_ACC_IMM : op[1] ? F_REG_RM : F_RM_REG;
                dec.cnt  = 2'd2;
                dec.imm1 = op[2:0] == 3'd4;
                dec.reg1 = ~op[0];
                dec.rw   = op[5:3] == 3'd7 ? 6'b000101 : 6'b000111;
            end else if (op[7:4] == 4'h4) begin
                dec.opc  = op[3] ? C_DEC : C_INC;
                dec.form = F_REG_OP;
                dec.cnt  = 2'd1;
                dec.rw   = 6'b000011;
            end else if (op[7:4] == 4'h5) begin
                dec.opc  = op[3] ? C_POP : C_PUSH;
                dec.form = F_REG_OP;
                dec.cnt  = 2'd1;
                dec.rw   = op[3] ? 6'b000010 : 6'b000001;
            end else if (op == 8'h69 || op == 8'h6B) begin
                dec.opc  = C_IMUL3;
                dec.form = F_REG_RM_IMM;
                dec.cnt  = 2'd3;
                dec.imm1 = op[1];
                dec.rw   = 6'b010110;
            end else if (op[7:4] == 4'h7) begin
                dec.opc  = C_JCC8;
                dec.form = F_REL;
                dec.cnt  = 2'd1;
                dec.imm1 = 1'b1;
                dec.rw   = 6'b000001;
            end else if (op[7:2] == 6'b100010) begin
                dec.opc  = C_MOV;
                dec.form = op[1] ? F_REG_RM : F_RM_REG;
                dec.cnt  = 2'd2;
                dec.reg1 = ~op[0];
                dec.rw   = 6'b000110;
            end else if (op == 8'h90) begin
                dec.opc  = C_NOP;
                dec.form = F_NONE;
            end else if (op == 8'hC3) begin
                dec.opc  = C_RET;
            end else if (op == 8'hE8 || op == 8'hEB) begin
                dec.opc  = op[1] ? C_JMP : C_CALL;
                dec.form = F_REL;
                dec.cnt  = 2'd1;
                dec.imm1 = op[1];
                dec.rw   = 6'b000001;
            end
        end else begin
            if (op[7:4] == 4'h8) begin
                dec.opc  = C_JCC32;
                dec.form = F_REL;
                dec.cnt  = 2'd1;
                dec.rw   = 6'b000001;
            end else if (op == 8'hAF) begin
                dec.opc  = C_IMUL2;
                dec.form = F_REG_RM;
                dec.cnt  = 2'd2;
                dec.rw   = 6'b000111;
            end else if (op[7:1] == 7'b1011011) begin
                dec.opc  = C_MOVZX;
                dec.form = F_REG_RM;
                dec.cnt  = 2'd2;
                dec.rw   = 6'b000110;
            end else if (op == 8'hA2) begin
                dec.opc  = C_CPUID;
            end
        end
        dec.ill = dec.opc == '0;
    end
    // record storage: written at the tail on push, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= dec;
    end
    // pointers and occupancy; flush and rst both empty the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // saturating illegal-push counter, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) illegal_cnt <= '0;
        else if (push && dec.ill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
    // head record, forced to zero while the queue is empty
    always_comb head = out_valid ? mem[rp] : '0;
    assign out_opc        = head.opc;
    assign out_opnd_form  = head.form;
    assign out_opnd_count = head.cnt;
    assign out_imm_1byte  = head.imm1;
    assign out_reg_1byte  = head.reg1;
    assign out_opnd_rw    = head.rw;
    assign out_illegal    = head.ill;
    assign out_instr      = head.instr;
endmodule

// File: tb/tb_decode_opc_queue.sv
// tb_decode_opc_queue: directed and random checks against a table-driven queue model
module tb_decode_opc_queue;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_is_2byte = 1'b0, out_ready = 1'b0;
    logic [71:0] in_instr = '0;
    logic        in_ready, out_valid, out_imm_1byte, out_reg_1byte, out_illegal;
    logic [5:0]  out_opc, out_opnd_rw;
    logic [3:0]  out_opnd_form;
    logic [1:0]  out_opnd_count;
    logic [71:0] out_instr;
    logic [2:0]  count;
    logic [7:0]  illegal_cnt;
    int checks = 0, errors = 0, mill = 0;
    int t_opc [512], t_form [512], t_cnt [512], t_imm [512], t_reg [512], t_rw [512];
    typedef struct { int opc, form, cnt, imm1, reg1, rw, ill; logic [71:0] instr; } exp_t;
    exp_t mq [$];
    logic [7:0] legal [18] = '{8'h01, 8'h00, 8'h03, 8'h05, 8'h2C, 8'h3D, 8'h41, 8'h55, 8'h5F,
                               8'h74, 8'h89, 8'h8A, 8'h90, 8'hC3, 8'hE8, 8'hEB, 8'h69, 8'h6B};

    decode_opc_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_is_2byte(in_is_2byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_opc(out_opc), .out_opnd_form(out_opnd_form), .out_opnd_count(out_opnd_count),
        .out_imm_1byte(out_imm_1byte), .out_reg_1byte(out_reg_1byte), .out_opnd_rw(out_opnd_rw),
        .out_illegal(out_illegal), .out_instr(out_instr), .count(count), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic put(input int i, input int opc, input int form, input int cnt, input int imm, input int reg1, input int rw);
        t_opc[i] = opc; t_form[i] = form; t_cnt[i] = cnt; t_imm[i] = imm; t_reg[i] = reg1; t_rw[i] = rw;
    endtask

    task automatic build_map();
        for (int i = 0; i < 512; i++) put(i, 0, 0, 0, 0, 0, 0);
        for (int g = 0; g < 8; g++)
            for (int k = 0; k < 6; k++)
                put(g * 8 + k, g + 1, k / 2 + 1, 2, int'(k == 4), int'(k % 2 == 0), g == 7 ? 5 : 7);
        for (int r = 0; r < 16; r++) begin
            put(64 + r, r < 8 ? 9 : 10, 4, 1, 0, 0, 3);
            put(80 + r, r < 8 ? 11 : 12, 4, 1, 0, 0, r < 8 ? 1 : 2);
            put(112 + r, 13, 5, 1, 1, 0, 1);
            put(256 + 128 + r, 19, 5, 1, 0, 0, 1);
        end
        put(8'h69, 23, 6, 3, 0, 0, 22);
        put(8'h6B, 23, 6, 3, 1, 0, 22);
        for (int m = 8'h88; m <= 8'h8B; m++) put(m, 14, m >= 8'h8A ? 2 : 1, 2, 0, int'(m % 2 == 0), 6);
        put(8'h90, 15, 0, 0, 0, 0, 0);
        put(8'hC3, 16, 0, 0, 0, 0, 0);
        put(8'hE8, 17, 5, 1, 0, 0, 1);
        put(8'hEB, 18, 5, 1, 1, 0, 1);
        put(256 + 8'hAF, 20, 2, 2, 0, 0, 7);
        put(256 + 8'hB6, 21, 2, 2, 0, 0, 6);
        put(256 + 8'hB7, 21, 2, 2, 0, 0, 6);
        put(256 + 8'hA2, 22, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t h;
        h = '{0, 0, 0, 0, 0, 0, 0, 72'h0};
        if (mq.size() != 0) h = mq[0];
        chk("count", count, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready", in_ready, mq.size() < 4);
        chk("illegal_cnt", illegal_cnt, mill);
        chk("opc", out_opc, h.opc);
        chk("form", out_opnd_form, h.form);
        chk("opnd_count", out_opnd_count, h.cnt);
        chk("imm_1byte", out_imm_1byte, h.imm1);
        chk("reg_1byte", out_reg_1byte, h.reg1);
        chk("rw", out_opnd_rw, h.rw);
        chk("illegal", out_illegal, h.ill);
        chk("instr", out_instr, h.instr);
    endtask

    task automatic step(input logic v, input logic [7:0] op, input logic is2, input logic rdy, input logic fl, input logic r);
        logic [95:0] w;
        exp_t e;
        int idx;
        bit do_push, do_pop;
        w = {$urandom, $urandom, $urandom};
        w[7:0] = op;
        in_valid = v; in_instr = w[71:0]; in_is_2byte = is2; out_ready = rdy; flush = fl; rst = r;
        idx = int'(is2) * 256 + int'(op);
        do_push = v && mq.size() < 4;
        do_pop = mq.size() != 0 && rdy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mill = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e = '{t_opc[idx], t_form[idx], t_cnt[idx], t_imm[idx], t_reg[idx], t_rw[idx],
                      int'(t_opc[idx] == 0), w[71:0]};
                mq.push_back(e);
                if (e.ill != 0 && mill < 255) mill++;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        build_map();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        // ADD r/m32,r32 then ADD r/m8,r8 then 2-byte IMUL
        step(1, 8'h01, 0, 0, 0, 0);
        chk("t1_reg1", out_reg_1byte, 0);
        chk("t1_cnt", out_opnd_count, 2);
        chk("t1_rw", out_opnd_rw, 6'b000111);
        chk("t1_ill", out_illegal, 0);
        step(1, 8'h00, 0, 0, 0, 0);
        step(1, 8'hAF, 1, 0, 0, 0);
        chk("t2_count", count, 3);
        step(0, 0, 0, 1, 0, 0);
        chk("t2_reg1", out_reg_1byte, 1);
        step(0, 0, 0, 1, 0, 0);
        chk("t2_imul", out_opc, 20);
        step(0, 0, 0, 1, 0, 0);
        // fill to DEPTH, hold a 5th word, one pop
        for (int i = 0; i < 4; i++) step(1, legal[$urandom_range(0, 17)], 0, 0, 0, 0);
        step(1, 8'h90, 0, 0, 0, 0);
        chk("t3_full_cnt", count, 4);
        chk("t3_full_rdy", in_ready, 0);
        step(1, 8'h90, 0, 1, 0, 0);
        chk("t3_after_pop", in_ready, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        // steady push+pop at count 2 wraps pointers
        step(1, legal[$urandom_range(0, 17)], 0, 0, 0, 0);
        step(1, legal[$urandom_range(0, 17)], 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, legal[$urandom_range(0, 17)], 0, 1, 0, 0);
        chk("t4_count", count, 2);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0);
        // 300 illegal opcodes saturate the counter
        for (int i = 0; i < 300; i++) step(1, 8'hFF, 0, 1, 0, 0);
        chk("t5_sat", illegal_cnt, 255);
        step(0, 0, 0, 1, 0, 0);
        // flush at count 3 drops the offered word
        for (int i = 0; i < 3; i++) step(1, legal[$urandom_range(0, 17)], 0, 0, 0, 0);
        step(1, 8'h01, 0, 0, 1, 0);
        chk("t6_count", count, 0);
        chk("t6_valid", out_valid, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // random traffic including rare flush and reset
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
        // reset mid-stream
        for (int i = 0; i < 3; i++) step(1, 8'h07, 0, 0, 0, 0);
        step(1, 8'h01, 0, 1, 1, 1);
        chk("t8_illcnt", illegal_cnt, 0);
        step(0, 0, 0, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
